serial_nibble_comparator: RTL and testbench
===========================================

// Module: serial_nibble_comparator
// PURPOSE
//  Compares two WIDTH-bit unsigned operands one 4-bit nibble per clock, least significant nibble first.
//  A cascadable 4-bit compare slice is reused every cycle.
//  The slice's eq/gt/lt outputs are registered and fed back as its cascade inputs on the next cycle.
//  Sits downstream of operand producers and gives a wide compare at the cost of one 4-bit slice.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of 4 and >= 4
//  NIB    WIDTH/4  derived (localparam); number of nibbles and RUN cycles
// PORTS
//  clk    in   1      single clock; all state updates on its rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request a compare; accepted only when busy==0
//  a      in   WIDTH  operand A; sampled on the accepted-start edge only
//  b      in   WIDTH  operand B; sampled on the accepted-start edge only
//  busy   out  1      high while a compare is in progress
//  done   out  1      one-cycle pulse: eq/gt/lt hold a new result
//  eq     out  1      result A==B; held until the next completion
//  gt     out  1      result A>B;  held until the next completion
//  lt     out  1      result A<B;  held until the next completion
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): state=IDLE, busy=0, done=0, eq=gt=lt=0 (no valid result).
//  - FSM states:
//    * IDLE --start--> RUN: capture a, b into shift regs; idx=0; cascade regs eq_c=1, gt_c=0, lt_c=0.
//    * RUN: each cycle the slice compares a_sh[3:0] with b_sh[3:0] using cascade inputs (eq_c, gt_c, lt_c).
//      Slice outputs are registered into the cascade regs; a_sh and b_sh shift right by 4; idx++.
//    * RUN with idx==NIB-1 --> DONE: the final slice outputs are written to eq/gt/lt (not only the cascade regs).
//    * DONE: done=1 for exactly this cycle, busy=0, then --> IDLE.
//      A start in DONE is accepted: capture as in IDLE and go to RUN.
//  - Slice function, per nibble:
//    * eq_o = (x==y) & eq_i
//    * gt_o = (x>y) | (gt_i & (x==y))
//    * lt_o = (x<y) | (lt_i & (x==y))
//    * A more significant nibble therefore overrides every less significant one.
//  - Latency: start sampled at edge T0; done is high during cycle T0+NIB+1 (16-bit: 5 cycles after start).
//  - busy: high from T0+1 through the last RUN cycle; low in IDLE and DONE.
//  - start while busy=1 is ignored entirely: operands are not re-sampled and the FSM is unaffected.
//  - eq/gt/lt change only on the DONE-entry edge. After the first completion exactly one of them is 1.
//  - a/b changing during RUN has no effect; only the captured copies are used.
//  - Reset asserted mid-RUN aborts the compare:
//    * all outputs return to reset values immediately;
//    * no done pulse is produced for the aborted request.
//  - idx width is clog2(NIB), minimum 1 bit. Unsigned compare only; no signed mode.
// STRUCTURE
//  - Shared package holds:
//    * state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//    * the NIBBLE=4 constant.
//  - Sub-module nibble_cascade_cmp is purely combinational:
//    * inputs x[3:0], y[3:0], eq_i, gt_i, lt_i;
//    * outputs eq_o, gt_o, lt_o;
//    * one instance, driven from the shift-register LSBs.
//  - The top level holds the FSM, shift regs, idx counter, cascade regs and result regs.
// TESTING  (WIDTH=16)
//  1. a=16'h1234, b=16'h1234, start pulse
//     -> done exactly 5 cycles later; eq=1, gt=0, lt=0; busy high for 4 cycles.
//  2. a=16'h8000, b=16'h7FFF (low nibbles say lt, MSB says gt)
//     -> gt=1, eq=0, lt=0 at done.
//  3. a=16'h00F0, b=16'h0100
//     -> lt=1; then a=16'hFFFF, b=16'h0000 started in the DONE cycle -> gt=1, done 5 cycles later.
//  4. start re-pulsed with a=0, b=16'hFFFF two cycles into a run of a=b=16'h0005
//     -> ignored; result eq=1; exactly one done pulse.
//  5. rst_n low for 1 cycle mid-RUN
//     -> busy=0, done=0, eq=gt=lt=0 at once; no done pulse; a new start afterwards completes normally.
//  6. Random a/b, 1000 runs
//     -> eq/gt/lt match the reference ==, >, <; one-hot after the first done; done never twice per start.

Source files
------------

// File: rtl/serial_nibble_comparator_pkg.sv
// Shared definitions for the serial nibble comparator: FSM state encoding
// and the slice width. Imported by the top level and the compare slice.
package serial_nibble_comparator_pkg;

  localparam int NIBBLE = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_nibble_comparator_cmp.sv
// nibble_cascade_cmp: combinational 4-bit unsigned compare slice with
// cascade inputs. The nibble being compared is more significant than
// whatever produced eq_i/gt_i/lt_i, so any inequality here overrides them.
//   x, y        : nibbles under compare
//   eq_i/gt_i/lt_i : result of the less significant nibbles
//   eq_o/gt_o/lt_o : combined result
module nibble_cascade_cmp
  import serial_nibble_comparator_pkg::*;
(
  input  logic [NIBBLE-1:0] x,
  input  logic [NIBBLE-1:0] y,
  input  logic              eq_i,
  input  logic              gt_i,
  input  logic              lt_i,
  output logic              eq_o,
  output logic              gt_o,
  output logic              lt_o
);

  logic same;
  assign same = (x == y);

  assign eq_o = same & eq_i;
  assign gt_o = (x > y) | (gt_i & same);
  assign lt_o = (x < y) | (lt_i & same);

endmodule

// File: rtl/serial_nibble_comparator.sv
// serial_nibble_comparator: WIDTH-bit unsigned compare done one nibble per
// clock, LSB nibble first, reusing a single cascade slice whose outputs are
// registered and fed back as its cascade inputs.
//   clk, rst_n : clock, async active-low reset
//   start      : request; accepted in IDLE or DONE
//   a, b       : operands, captured on the accepted-start edge
//   busy       : compare in progress (RUN state)
//   done       : one-cycle pulse when eq/gt/lt are updated
//   eq, gt, lt : result, held until the next completion
module serial_nibble_comparator
  import serial_nibble_comparator_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NIB   = WIDTH / NIBBLE;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_c_q, eq_c_d, gt_c_q, gt_c_d, lt_c_q, lt_c_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             s_eq, s_gt, s_lt;

  nibble_cascade_cmp u_slice (
    .x    (a_sh_q[NIBBLE-1:0]),
    .y    (b_sh_q[NIBBLE-1:0]),
    .eq_i (eq_c_q),
    .gt_i (gt_c_q),
    .lt_i (lt_c_q),
    .eq_o (s_eq),
    .gt_o (s_gt),
    .lt_o (s_lt)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    idx_d   = idx_q;
    eq_c_d  = eq_c_q;
    gt_c_d  = gt_c_q;
    lt_c_d  = lt_c_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE behaves like IDLE for acceptance so back-to-back compares
        // lose no cycle.
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          a_sh_d  = a;
          b_sh_d  = b;
          idx_d   = '0;
          eq_c_d  = 1'b1;
          gt_c_d  = 1'b0;
          lt_c_d  = 1'b0;
        end
      end
      S_RUN: begin
        eq_c_d = s_eq;
        gt_c_d = s_gt;
        lt_c_d = s_lt;
        a_sh_d = a_sh_q >> NIBBLE;
        b_sh_d = b_sh_q >> NIBBLE;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          eq_d    = s_eq;
          gt_d    = s_gt;
          lt_d    = s_lt;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      eq_c_q  <= 1'b1;
      gt_c_q  <= 1'b0;
      lt_c_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      eq_c_q  <= eq_c_d;
      gt_c_q  <= gt_c_d;
      lt_c_q  <= lt_c_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_nibble_comparator.sv
// Bench for serial_nibble_comparator (WIDTH=16). Stimulus pushes the
// expected result and the cycle it must appear into a queue; a monitor pops
// on every done pulse and checks value, timing and one-hotness.
module tb_serial_nibble_comparator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, eq, gt, lt;

  serial_nibble_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic eq, gt, lt;
    int   due;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_eqgtlt", {29'd0, eq, gt, lt}, {29'd0, e.eq, e.gt, e.lt});
        check("done_latency", cyc, e.due);
        check("onehot", $countones({eq, gt, lt}), 1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called at a negedge: start is sampled on the next posedge, and the
  // result must appear five negedge samples after this one.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit expect_done);
    exp_t e;
    a = av; b = bv; start = 1'b1;
    e.eq = (av == bv); e.gt = (av > bv); e.lt = (av < bv); e.due = cyc + 5;
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic e_eq, input logic e_gt, input logic e_lt);
    exp_t e;
    e.eq = e_eq; e.gt = e_gt; e.lt = e_lt; e.due = cyc + 5;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 20 && !done; i++) @(negedge clk);
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int bcnt;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_eqgtlt", {29'd0, eq, gt, lt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_eqgtlt", {29'd0, eq, gt, lt}, 32'd0);

    // 1: equal operands, busy for 4 samples
    a = 16'h1234; b = 16'h1234; start = 1'b1; push_exp(1'b1, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("t1_busy_cycles", bcnt, 4);
    check("t1_done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, done}, 32'd0);
    check("t1_result_held", {29'd0, eq, gt, lt}, 32'b100);

    // 2: MSB nibble overrides low nibbles
    a = 16'h8000; b = 16'h7FFF; start = 1'b1; push_exp(1'b0, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_done("t2");
    @(negedge clk);

    // 3: lt, then a new start in the DONE cycle
    a = 16'h00F0; b = 16'h0100; start = 1'b1; push_exp(1'b0, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0;
    wait_done("t3a");
    a = 16'hFFFF; b = 16'h0000; start = 1'b1; push_exp(1'b0, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    check("t3_busy_after_done_start", {31'd0, busy}, 32'd1);
    wait_done("t3b");
    @(negedge clk);

    // 4: restart while busy is ignored, operands changing mid-run ignored
    a = 16'h0005; b = 16'h0005; start = 1'b1; push_exp(1'b1, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    a = 16'h0000; b = 16'hFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("t4");
    repeat (8) @(negedge clk);
    check("t4_no_extra_done", sb.size(), 0);

    // 5: reset mid-run aborts without a done pulse
    issue(16'h0003, 16'h0004, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_eqgtlt", {29'd0, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_still_cleared", {29'd0, eq, gt, lt}, 32'd0);
    a = 16'h0003; b = 16'h0004; start = 1'b1; push_exp(1'b0, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0;
    wait_done("t5_after");
    @(negedge clk);

    // 6: random operands, mixed with forced equal / near-equal pairs
    for (int r = 0; r < 1000; r++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (r % 4 == 0) rb = ra;
      else if (r % 4 == 1) rb = ra ^ W'(16'h1 << (4 * (r % 16 / 4)));
      issue(ra, rb, 1'b1);
      wait_done("t6");
      if (r % 3 != 0) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
